// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch slice: widths, reset PC and the
// canonical NOP presented to decode when nothing is buffered.
package fetch_unit_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int IMEM_W       = 32;

    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [IMEM_W-1:0]       INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: instruction-memory req/gnt/rvalid bus, execute
// redirect, and the valid/ready hand-off to decode.
interface fetch_unit_if #(
    parameter int XLEN = fetch_unit_pkg::XLEN_DEFAULT
);
    logic                              o_imem_req;
    logic [XLEN-1:0]                   o_imem_addr;
    logic                              i_imem_gnt;
    logic                              i_imem_rvalid;
    logic [fetch_unit_pkg::IMEM_W-1:0] i_imem_rdata;
    logic                              i_redirect;
    logic [XLEN-1:0]                   i_redirect_pc;
    logic                              o_if_valid;
    logic [XLEN-1:0]                   o_if_pc;
    logic [fetch_unit_pkg::IMEM_W-1:0] o_if_instr;
    logic                              i_id_ready;

    modport master (
        output o_imem_req, o_imem_addr, o_if_valid, o_if_pc, o_if_instr,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  i_redirect, i_redirect_pc, i_id_ready
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_if_valid, o_if_pc, o_if_instr,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output i_redirect, i_redirect_pc, i_id_ready
    );

endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous FIFO with single-cycle flush and occupancy count; the head entry
// is read combinationally so the consumer sees it in the cycle it becomes valid.
module fetch_unit_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot a same-cycle push lands in, so push-while-full is legal.
    assign do_pop  = i_pop && (count != '0);
    assign do_push = i_push && ((count != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the count alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) mem[wr_ptr] <= i_push_data;
    end

    assign o_head  = mem[rd_ptr];
    assign o_count = count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches,
// buffers responses for decode and drains stale responses after a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN            = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEFAULT),
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input logic          i_clk,
    input logic          i_rst,
    fetch_unit_if.master bus
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = ((OW > CW) ? OW : CW) + 1;
    localparam int EW = XLEN + IMEM_W;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   fifo_head;
    logic [XLEN-1:0] redirect_target;
    logic            credit_ok;
    logic            accept;
    logic            rsp_live;
    logic            fifo_valid;
    logic            push;
    logic            pop;

    // Word-align the target by clearing the two low bits.
    assign redirect_target = bus.i_redirect_pc & ~XLEN'(3);

    // A response with nothing in flight cannot belong to us (e.g. left over from before reset).
    assign rsp_live = bus.i_imem_rvalid && (outstanding != '0);

    // Counting in-flight requests against buffer space means every response has a slot waiting.
    assign credit_ok = (outstanding < OW'(MAX_OUTSTANDING)) &&
                       ((SW'(outstanding) + SW'(fifo_count)) < SW'(FIFO_DEPTH));

    assign bus.o_imem_req  = !i_rst && !bus.i_redirect && credit_ok;
    assign bus.o_imem_addr = fetch_pc;
    assign accept          = bus.o_imem_req && bus.i_imem_gnt;

    assign fifo_valid     = (fifo_count != '0);
    assign bus.o_if_valid = fifo_valid && !bus.i_redirect && !i_rst;
    assign bus.o_if_pc    = fifo_head[EW-1:IMEM_W];
    assign bus.o_if_instr = fifo_valid ? fifo_head[IMEM_W-1:0] : INSTR_NOP;

    assign push = rsp_live && (discard == '0) && !bus.i_redirect;
    assign pop  = bus.o_if_valid && bus.i_id_ready;

    fetch_unit_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (bus.i_redirect),
        .i_push      (push),
        .i_push_data ({resp_pc, bus.i_imem_rdata}),
        .i_pop       (pop),
        .o_head      (fifo_head),
        .o_count     (fifo_count)
    );

    // NOTE: state registers use non-blocking assignments so every term reads pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (bus.i_redirect) begin
            fetch_pc    <= redirect_target;
            resp_pc     <= redirect_target;
            outstanding <= outstanding - OW'(rsp_live);
            // Everything still in flight belongs to an abandoned stream, whether or not
            // an earlier redirect had already marked it, so the drain count is exact.
            discard     <= outstanding - OW'(rsp_live);
        end else begin
            if (accept) fetch_pc <= fetch_pc + XLEN'(4);
            outstanding <= outstanding + OW'(accept) - OW'(rsp_live);
            if (rsp_live) begin
                if (discard != '0) discard <= discard - 1'b1;
                else               resp_pc <= resp_pc + XLEN'(4);
            end
        end
    end

endmodule
